// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC word aligner: word/offset widths,
// the default training word and the lane state encoding.
package adc_pkg;

  localparam int unsigned WORD_W    = 12;
  localparam int unsigned WIN_W     = 2 * WORD_W;
  localparam int unsigned OFFSET_W  = 4;
  localparam int unsigned NUM_LANES = 4;

  localparam logic [WORD_W-1:0]   TRAIN_PAT_DEFAULT = 12'hFC0;
  localparam logic [OFFSET_W-1:0] K_LAST            = OFFSET_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAIL   = 2'd3
  } lane_state_e;

  typedef struct packed {
    lane_state_e           state;
    logic [OFFSET_W-1:0]   offset;
  } lane_status_t;

  // Select the word starting k bits up from the bottom of the {prev, raw} window.
  function automatic logic [WORD_W-1:0] align_word(input logic [WIN_W-1:0]    win,
                                                   input logic [OFFSET_W-1:0] k);
    logic [WIN_W-1:0] sh;
    sh = win >> k;
    return sh[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/adc_lane_align.sv
// One lane of the word aligner: slides a 12-bit view across the {prev, raw}
// window until the training word is seen LOCK_COUNT times in a row.
module adc_lane_align
  import adc_pkg::*;
#(
  parameter logic [WORD_W-1:0] TRAIN_PAT  = TRAIN_PAT_DEFAULT,
  parameter int unsigned       LOCK_COUNT = 8,
  parameter int unsigned       MAX_SWEEPS = 2
) (
  input  logic              fclk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [WORD_W-1:0] i_raw,
  output logic [WORD_W-1:0] o_dat,
  output lane_status_t      o_status
);

  localparam int unsigned     MC_W    = $clog2(LOCK_COUNT + 1);
  localparam int unsigned     SC_W    = $clog2(MAX_SWEEPS + 1);
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(LOCK_COUNT - 1);
  localparam logic [MC_W-1:0] MC_FULL = MC_W'(LOCK_COUNT);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(MAX_SWEEPS - 1);
  localparam logic [SC_W-1:0] SC_FULL = SC_W'(MAX_SWEEPS);

  lane_state_e         r_state;
  lane_state_e         w_state_nxt;
  logic [OFFSET_W-1:0] r_k;
  logic [OFFSET_W-1:0] w_k_nxt;
  logic [MC_W-1:0]     r_match_cnt;
  logic [MC_W-1:0]     w_match_cnt_nxt;
  logic [SC_W-1:0]     r_sweep_cnt;
  logic [SC_W-1:0]     w_sweep_cnt_nxt;
  logic [WORD_W-1:0]   r_prev;
  logic [WORD_W-1:0]   r_dat;
  logic [WORD_W-1:0]   w_aligned;
  logic                w_match;

  assign w_aligned = align_word({r_prev, i_raw}, r_k);
  assign w_match   = (w_aligned == TRAIN_PAT);

  // State and counters; prev and the output word update every cycle.
  always_ff @(posedge fclk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_match_cnt <= '0;
      r_sweep_cnt <= '0;
      r_prev      <= '0;
      r_dat       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_match_cnt <= w_match_cnt_nxt;
      r_sweep_cnt <= w_sweep_cnt_nxt;
      r_prev      <= i_raw;
      r_dat       <= w_aligned;
    end
  end

  // Search sequencing; a start overrides whatever the current state would do.
  always_comb begin
    w_state_nxt     = r_state;
    w_k_nxt         = r_k;
    w_match_cnt_nxt = r_match_cnt;
    w_sweep_cnt_nxt = r_sweep_cnt;

    if (i_start) begin
      w_state_nxt     = ST_SEARCH;
      w_k_nxt         = '0;
      w_match_cnt_nxt = '0;
      w_sweep_cnt_nxt = '0;
    end else begin
      unique case (r_state)
        ST_SEARCH: begin
          if (w_match) begin
            if (r_match_cnt == MC_LAST) begin
              w_state_nxt     = ST_LOCKED;
              w_match_cnt_nxt = MC_FULL;
            end else begin
              w_match_cnt_nxt = r_match_cnt + MC_W'(1);
            end
          end else begin
            w_match_cnt_nxt = '0;
            if (r_k == K_LAST) begin
              w_k_nxt = '0;
              // Wrapping off the last offset completes one sweep.
              if (r_sweep_cnt == SC_LAST) begin
                w_state_nxt     = ST_FAIL;
                w_sweep_cnt_nxt = SC_FULL;
              end else begin
                w_sweep_cnt_nxt = r_sweep_cnt + SC_W'(1);
              end
            end else begin
              w_k_nxt = r_k + OFFSET_W'(1);
            end
          end
        end
        ST_IDLE, ST_LOCKED, ST_FAIL: begin
          w_state_nxt = r_state;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign o_dat    = r_dat;
  assign o_status = '{state: r_state, offset: r_k};

endmodule

// File: rtl/adc_word_align.sv
// Four-lane ADC word aligner: detects train_en rising edges, runs one
// alignment lane per ADC channel and aggregates lock/fail status.
module adc_word_align
  import adc_pkg::*;
#(
  parameter logic [WORD_W-1:0] TRAIN_PAT  = TRAIN_PAT_DEFAULT,
  parameter int unsigned       LOCK_COUNT = 8,
  parameter int unsigned       MAX_SWEEPS = 2
) (
  input  logic                          fclk,
  input  logic                          reset,
  input  logic                          train_en,
  input  logic [WORD_W-1:0]             raw_A,
  input  logic [WORD_W-1:0]             raw_B,
  input  logic [WORD_W-1:0]             raw_C,
  input  logic [WORD_W-1:0]             raw_D,
  output logic [WORD_W-1:0]             dat_A,
  output logic [WORD_W-1:0]             dat_B,
  output logic [WORD_W-1:0]             dat_C,
  output logic [WORD_W-1:0]             dat_D,
  output logic                          dat_valid,
  output logic                          align_err,
  output logic [NUM_LANES*OFFSET_W-1:0] offsets
);

  logic                                 r_train_en_q;
  logic                                 r_start_armed;
  logic                                 r_dat_valid;
  logic                                 r_align_err;
  logic                                 w_start;
  logic                                 w_all_locked;
  logic                                 w_any_fail;
  logic [NUM_LANES-1:0][WORD_W-1:0]     w_raw;
  logic [NUM_LANES-1:0][WORD_W-1:0]     w_dat;
  lane_status_t [NUM_LANES-1:0]         w_status;
  logic [NUM_LANES*OFFSET_W-1:0]        w_offsets;

  assign w_raw = {raw_D, raw_C, raw_B, raw_A};

  // A level held across reset is not an edge: starts are only honoured once
  // train_en has been seen low since the last reset.
  assign w_start = train_en & ~r_train_en_q & r_start_armed;

  always_ff @(posedge fclk) begin
    if (reset) begin
      r_train_en_q  <= 1'b0;
      r_start_armed <= 1'b0;
      r_dat_valid   <= 1'b0;
      r_align_err   <= 1'b0;
    end else begin
      r_train_en_q  <= train_en;
      if (!train_en) begin
        r_start_armed <= 1'b1;
      end
      r_dat_valid   <= w_all_locked;
      r_align_err   <= w_any_fail;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    adc_lane_align #(
      .TRAIN_PAT  (TRAIN_PAT),
      .LOCK_COUNT (LOCK_COUNT),
      .MAX_SWEEPS (MAX_SWEEPS)
    ) u_lane (
      .fclk     (fclk),
      .reset    (reset),
      .i_start  (w_start),
      .i_raw    (w_raw[l]),
      .o_dat    (w_dat[l]),
      .o_status (w_status[l])
    );
  end

  // Status reduction across lanes and packing of the per-lane offsets.
  always_comb begin
    w_all_locked = 1'b1;
    w_any_fail   = 1'b0;
    w_offsets    = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      w_all_locked = w_all_locked & (w_status[l].state == ST_LOCKED);
      w_any_fail   = w_any_fail | (w_status[l].state == ST_FAIL);
      w_offsets[l*OFFSET_W +: OFFSET_W] = w_status[l].offset;
    end
  end

  assign dat_A     = w_dat[0];
  assign dat_B     = w_dat[1];
  assign dat_C     = w_dat[2];
  assign dat_D     = w_dat[3];
  assign dat_valid = r_dat_valid;
  assign align_err = r_align_err;
  assign offsets   = w_offsets;

endmodule

// File: tb/tb_adc_word_align.sv
// Bench for adc_word_align: directed alignment scenarios plus a randomized
// phase, all checked against a cycle-level behavioural model of the lanes.
module tb_adc_word_align;

  localparam logic [11:0] PAT    = 12'hFC0;
  localparam int          LOCKN  = 8;
  localparam int          SWEEPS = 2;
  localparam int          M_IDLE = 0, M_SEARCH = 1, M_LOCKED = 2, M_FAIL = 3;

  logic        fclk = 1'b0;
  logic        reset;
  logic        train_en;
  logic [11:0] raw_A, raw_B, raw_C, raw_D;
  logic [11:0] dat_A, dat_B, dat_C, dat_D;
  logic        dat_valid;
  logic        align_err;
  logic [15:0] offsets;

  always #5 fclk = ~fclk;

  adc_word_align dut (
    .fclk      (fclk),
    .reset     (reset),
    .train_en  (train_en),
    .raw_A     (raw_A),
    .raw_B     (raw_B),
    .raw_C     (raw_C),
    .raw_D     (raw_D),
    .dat_A     (dat_A),
    .dat_B     (dat_B),
    .dat_C     (dat_C),
    .dat_D     (dat_D),
    .dat_valid (dat_valid),
    .align_err (align_err),
    .offsets   (offsets)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state; m_hist is the last sampled train_en, -1 when unknown.
  logic [11:0] m_prev [4];
  logic [11:0] m_dat  [4];
  int          m_k    [4];
  int          m_mc   [4];
  int          m_sc   [4];
  int          m_st   [4];
  int          m_hist;
  logic        m_valid, m_err;

  function automatic logic [11:0] rotl(input logic [11:0] p, input int n);
    logic [23:0] d;
    d = {p, p};
    d = d << n;
    return d[23:12];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic ten, input logic [3:0][11:0] r);
    logic        start, all_l, any_f;
    logic [23:0] win;
    logic [11:0] al;
    if (rst) begin
      for (int l = 0; l < 4; l++) begin
        m_prev[l] = '0; m_dat[l] = '0; m_k[l] = 0; m_mc[l] = 0; m_sc[l] = 0; m_st[l] = M_IDLE;
      end
      m_hist = -1; m_valid = 1'b0; m_err = 1'b0;
    end else begin
      start = ten && (m_hist == 0);
      all_l = 1'b1;
      any_f = 1'b0;
      for (int l = 0; l < 4; l++) begin
        all_l = all_l && (m_st[l] == M_LOCKED);
        any_f = any_f || (m_st[l] == M_FAIL);
      end
      for (int l = 0; l < 4; l++) begin
        win = {m_prev[l], r[l]};
        al  = 12'(win >> m_k[l]);
        m_dat[l] = al;
        if (start) begin
          m_st[l] = M_SEARCH; m_k[l] = 0; m_mc[l] = 0; m_sc[l] = 0;
        end else if (m_st[l] == M_SEARCH) begin
          if (al == PAT) begin
            m_mc[l] = m_mc[l] + 1;
            if (m_mc[l] >= LOCKN) begin m_mc[l] = LOCKN; m_st[l] = M_LOCKED; end
          end else begin
            m_mc[l] = 0;
            m_k[l]  = m_k[l] + 1;
            if (m_k[l] == 12) begin
              m_k[l]  = 0;
              m_sc[l] = m_sc[l] + 1;
              if (m_sc[l] >= SWEEPS) m_st[l] = M_FAIL;
            end
          end
        end
        m_prev[l] = r[l];
      end
      m_valid = all_l;
      m_err   = any_f;
      m_hist  = ten ? 1 : 0;
    end
  endtask

  task automatic check_all();
    logic [15:0] exp_off;
    exp_off = {4'(m_k[3]), 4'(m_k[2]), 4'(m_k[1]), 4'(m_k[0])};
    check("dat_A", dat_A, m_dat[0]);
    check("dat_B", dat_B, m_dat[1]);
    check("dat_C", dat_C, m_dat[2]);
    check("dat_D", dat_D, m_dat[3]);
    check("dat_valid", dat_valid, m_valid);
    check("align_err", align_err, m_err);
    check("offsets", offsets, exp_off);
  endtask

  task automatic tick();
    logic [3:0][11:0] r;
    logic rs, te;
    r  = {raw_D, raw_C, raw_B, raw_A};
    rs = reset;
    te = train_en;
    @(posedge fclk);
    model_step(rs, te, r);
    #1;
    check_all();
  endtask

  task automatic set_raw(input logic [11:0] a, b, c, d);
    raw_A = a; raw_B = b; raw_C = c; raw_D = d;
  endtask

  // Clock until dat_valid (or align_err) is seen, within a cycle budget.
  task automatic wait_flag(input string tag, input bit want_err, input int budget, output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    while (n < budget && !seen) begin
      tick();
      n++;
      seen = want_err ? (align_err === 1'b1) : (dat_valid === 1'b1);
    end
    check(tag, seen, 1'b1);
  endtask

  task automatic pulse_start();
    train_en = 1'b1;
    tick();
    train_en = 1'b0;
  endtask

  initial begin
    int n;
    int offs [4];
    logic [11:0] w;

    reset = 1'b1; train_en = 1'b0;
    set_raw('0, '0, '0, '0);
    tick();
    tick();
    check("rst_valid", dat_valid, 1'b0);
    check("rst_offsets", offsets, 16'h0000);
    reset = 1'b0;
    tick();

    // Four lanes at different slips lock together.
    set_raw(rotl(PAT, 0), rotl(PAT, 3), rotl(PAT, 7), rotl(PAT, 11));
    tick();
    pulse_start();
    wait_flag("multi_wait", 1'b0, 30, n);
    check("multi_latency", 16'(n), 16'd20);
    check("multi_offsets", offsets, 16'hB730);
    check("multi_datA", dat_A, PAT);
    check("multi_datD", dat_D, PAT);

    // Lane A sees the training word slipped by 5.
    set_raw(12'h81F, rotl(PAT, 2), rotl(PAT, 9), rotl(PAT, 4));
    tick();
    pulse_start();
    wait_flag("slip5_wait", 1'b0, 30, n);
    check("slip5_offA", offsets[3:0], 4'd5);
    check("slip5_datA", dat_A, PAT);

    // New start on the same cycle as the 8th match restarts the search.
    set_raw(PAT, PAT, PAT, PAT);
    tick();
    pulse_start();
    repeat (7) tick();
    train_en = 1'b1;
    tick();
    train_en = 1'b0;
    check("coinc_offB", offsets[7:4], 4'd0);
    tick();
    check("coinc_valid", dat_valid, 1'b0);
    wait_flag("coinc_wait", 1'b0, 30, n);
    check("coinc_latency", 16'(n), 16'd8);

    // One corrupted word after 5 matches forces a further sweep.
    pulse_start();
    repeat (5) tick();
    raw_A = 12'h000;
    tick();
    check("corrupt_offA", offsets[3:0], 4'd1);
    raw_A = PAT;
    wait_flag("corrupt_wait", 1'b0, 40, n);
    check("corrupt_latency", 16'(n), 16'd20);
    check("corrupt_offsets", offsets, 16'h0000);

    // Lane C never sees the pattern and fails after two sweeps.
    raw_C = 12'h123;
    tick();
    pulse_start();
    wait_flag("fail_wait", 1'b1, 40, n);
    check("fail_latency", 16'(n), 16'd25);
    check("fail_valid", dat_valid, 1'b0);
    check("fail_offC", offsets[11:8], 4'd0);

    // Reset while locked, with train_en held high through and after it.
    raw_C = PAT;
    pulse_start();
    wait_flag("relock_wait", 1'b0, 30, n);
    check("relock_latency", 16'(n), 16'd9);
    reset = 1'b1; train_en = 1'b1;
    tick();
    check("lrst_valid", dat_valid, 1'b0);
    check("lrst_offsets", offsets, 16'h0000);
    check("lrst_datA", dat_A, 12'h000);
    reset = 1'b0;
    repeat (20) tick();
    check("held_valid", dat_valid, 1'b0);
    check("held_err", align_err, 1'b0);
    train_en = 1'b0;
    tick();
    pulse_start();
    wait_flag("toggle_wait", 1'b0, 30, n);
    check("toggle_latency", 16'(n), 16'd9);

    // Randomized traffic: slips, noise, garbage lanes, train_en and reset.
    for (int c = 0; c < 320; c++) begin
      if (c % 64 == 0) begin
        for (int l = 0; l < 4; l++) offs[l] = $urandom_range(0, 11);
        if ($urandom_range(0, 2) == 0) offs[$urandom_range(0, 3)] = 12;
      end
      for (int l = 0; l < 4; l++) begin
        w = (offs[l] == 12) ? 12'h123 : rotl(PAT, offs[l]);
        if ($urandom_range(0, 49) == 0) w = 12'($urandom);
        case (l)
          0: raw_A = w;
          1: raw_B = w;
          2: raw_C = w;
          default: raw_D = w;
        endcase
      end
      if ($urandom_range(0, 24) == 0) train_en = ~train_en;
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
